// File: rtl/prism_sit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prism_sit_pkg
// Purpose  : Shared constants for the multi-channel latch-based PRISM SIT.
// Revision : 1.0
// ============================================================================
package prism_sit_pkg;

    localparam logic [5:0] STAGE_BASE = 6'h00;
    localparam logic [5:0] CMD        = 6'h10;
    localparam logic [5:0] STATUS     = 6'h14;
    localparam logic [5:0] RDSEL      = 6'h18;
    localparam logic [5:0] RB_BASE    = 6'h20;

    localparam int FLD_ROW_LSB  = 0;
    localparam int FLD_ROW_W    = 6;
    localparam int FLD_CHAN_LSB = 8;
    localparam int FLD_CHAN_W   = 3;
    localparam int FLD_GO       = 31;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_ERR   = 1;
    localparam int STATUS_PERR  = 2;

    // Widest row image visible through the four 32-bit debug windows.
    localparam int DBG_BITS     = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_GATE  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic int words_for(input int width);
        return (width + 31) / 32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prism_sit_latch_bank.sv
`default_nettype none
// ============================================================================
// Module   : prism_sit_latch_bank
// Purpose  : One channel's DEPTH x (WIDTH+PAR_W) latch array with async clear,
//            per-row gates, a state-machine read port and a debug read port.
// Revision : 1.0
// ============================================================================
module prism_sit_latch_bank #(
    parameter int WIDTH  = 80,
    parameter int DEPTH  = 4,
    parameter int A_BITS = 2,
    parameter int PAR_W  = 0
) (
    input  logic                     rst_n,
    input  logic [DEPTH-1:0]         gate,
    input  logic [WIDTH+PAR_W-1:0]   wdata,
    input  logic [A_BITS-1:0]        raddr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_perr,
    input  logic [5:0]               dbg_row,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int SW = WIDTH + PAR_W;

    logic [SW-1:0] w_mem [DEPTH];
    logic [SW-1:0] w_rd;

    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        logic [SW-1:0] r_mem;
        always_latch begin
            if (!rst_n) begin
                r_mem <= '0;
            end else if (gate[r]) begin
                r_mem <= wdata;
            end
        end
        assign w_mem[r] = r_mem;
    end

    always_comb begin
        w_rd = '0;
        if (32'(raddr) < DEPTH) begin
            w_rd = w_mem[raddr];
        end
    end

    always_comb begin
        dbg_data = '0;
        if (32'(dbg_row) < DEPTH) begin
            dbg_data = w_mem[dbg_row[A_BITS-1:0]][WIDTH-1:0];
        end
    end

    assign rd_data = w_rd[WIDTH-1:0];

    // Even parity: a healthy row (data plus parity bit) always XORs to zero.
    if (PAR_W > 0) begin : g_par
        assign rd_perr = ^w_rd;
    end else begin : g_nopar
        assign rd_perr = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/prism_latch_sit_mc.sv
`default_nettype none
// ============================================================================
// Module   : prism_latch_sit_mc
// Purpose  : NCH-channel latch SIT with random-access debug programming and a
//            flop-gated commit sequencer. Macro PRISM_SIT_PARITY_EN adds parity.
// Revision : 1.0
// ============================================================================
module prism_latch_sit_mc
    import prism_sit_pkg::*;
#(
    parameter int WIDTH  = 80,
    parameter int DEPTH  = 4,
    parameter int NCH    = 2,
    parameter int A_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              debug_addr,
    input  logic                    debug_wr,
    input  logic [31:0]             debug_wdata,
    output logic [31:0]             debug_rdata,
    input  logic [NCH*A_BITS-1:0]   raddr,
    output logic [NCH*WIDTH-1:0]    rdata,
    output logic                    busy,
    output logic [NCH-1:0]          rdata_perr
);

    localparam int WORDS = words_for(WIDTH);
`ifdef PRISM_SIT_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int SW = WIDTH + PAR_W;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_err;
    logic [WIDTH-1:0]        r_stage;
    logic [5:0]              r_rd_row;
    logic [2:0]              r_rd_chan;
    logic [5:0]              r_cmd_row;
    logic [2:0]              r_cmd_chan;
    logic [SW-1:0]           r_wbus;
    logic [SW-1:0]           w_wbus;
    logic [NCH*DEPTH-1:0]    r_gate;
    logic [NCH*DEPTH-1:0]    w_gate_nxt;

    logic                    w_aligned;
    logic [1:0]              w_idx;
    logic                    w_sel_stage;
    logic                    w_sel_rb;
    logic                    w_wr_stage;
    logic                    w_wr_cmd;
    logic                    w_wr_status;
    logic                    w_wr_rdsel;
    logic                    w_go;
    logic [5:0]              w_cmd_row;
    logic [2:0]              w_cmd_chan;
    logic                    w_cmd_ok;
    logic                    w_accept;
    logic                    w_err_set;
    logic                    w_err_clr;
    logic [2:0]              w_status;
    logic [WIDTH-1:0]        w_dbg_ch [NCH];
    logic [WIDTH-1:0]        w_rb;
    logic [DBG_BITS-1:0]     w_rb_pad;
    logic [DBG_BITS-1:0]     w_stage_pad;

    // ---------------- debug bus decode ----------------
    assign w_aligned   = (debug_addr[1:0] == 2'b00);
    assign w_idx       = debug_addr[3:2];
    assign w_sel_stage = w_aligned && (debug_addr[5:4] == STAGE_BASE[5:4]) && (32'(w_idx) < WORDS);
    assign w_sel_rb    = w_aligned && (debug_addr[5:4] == RB_BASE[5:4]);
    assign w_wr_stage  = debug_wr && w_sel_stage;
    assign w_wr_cmd    = debug_wr && (debug_addr == CMD);
    assign w_wr_status = debug_wr && (debug_addr == STATUS);
    assign w_wr_rdsel  = debug_wr && (debug_addr == RDSEL);

    assign w_go        = w_wr_cmd && debug_wdata[FLD_GO];
    assign w_cmd_row   = debug_wdata[FLD_ROW_LSB +: FLD_ROW_W];
    assign w_cmd_chan  = debug_wdata[FLD_CHAN_LSB +: FLD_CHAN_W];
    assign w_cmd_ok    = (32'(w_cmd_row) < DEPTH) && (32'(w_cmd_chan) < NCH);
    assign w_accept    = w_go && !busy && w_cmd_ok;
    assign w_err_set   = (w_go && (busy || !w_cmd_ok)) || (w_wr_stage && busy);
    assign w_err_clr   = w_wr_status && debug_wdata[STATUS_ERR];

`ifdef PRISM_SIT_PARITY_EN
    assign w_wbus = {^r_stage, r_stage};
`else
    assign w_wbus = r_stage;
`endif

    // ---------------- commit FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_SETUP;
            ST_SETUP: w_state_nxt = ST_GATE;
            ST_GATE:  w_state_nxt = ST_HOLD;
            ST_HOLD:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    // Gates are decoded one cycle early so each latch enable comes straight off a flop.
    always_comb begin
        w_gate_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if ((w_state_nxt == ST_GATE) && (32'(r_cmd_chan) == c) && (32'(r_cmd_row) == r)) begin
                    w_gate_nxt[c*DEPTH + r] = 1'b1;
                end
            end
        end
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_stage    <= '0;
            r_rd_row   <= '0;
            r_rd_chan  <= '0;
            r_cmd_row  <= '0;
            r_cmd_chan <= '0;
            r_wbus     <= '0;
            r_gate     <= '0;
        end else begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_wr_stage && !busy) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if ((i / 32) == int'(w_idx)) begin
                        r_stage[i] <= debug_wdata[i % 32];
                    end
                end
            end
            if (w_wr_rdsel) begin
                r_rd_row  <= w_cmd_row;
                r_rd_chan <= w_cmd_chan;
            end
            if (w_accept) begin
                r_cmd_row  <= w_cmd_row;
                r_cmd_chan <= w_cmd_chan;
                r_wbus     <= w_wbus;
            end
            r_gate <= w_gate_nxt;
        end
    end

    // ---------------- latch banks ----------------
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        prism_sit_latch_bank #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .A_BITS (A_BITS),
            .PAR_W  (PAR_W)
        ) u_bank (
            .rst_n    (rst_n),
            .gate     (r_gate[c*DEPTH +: DEPTH]),
            .wdata    (r_wbus),
            .raddr    (raddr[c*A_BITS +: A_BITS]),
            .rd_data  (rdata[c*WIDTH +: WIDTH]),
            .rd_perr  (rdata_perr[c]),
            .dbg_row  (r_rd_row),
            .dbg_data (w_dbg_ch[c])
        );
    end

    // ---------------- debug read mux ----------------
    always_comb begin
        w_rb = '0;
        for (int c = 0; c < NCH; c++) begin
            if (32'(r_rd_chan) == c) begin
                w_rb = w_dbg_ch[c];
            end
        end
    end

    assign w_rb_pad    = DBG_BITS'(w_rb);
    assign w_stage_pad = DBG_BITS'(r_stage);

    always_comb begin
        w_status                = '0;
        w_status[STATUS_BUSY]   = busy;
        w_status[STATUS_ERR]    = r_err;
        w_status[STATUS_PERR]   = |rdata_perr;
    end

    always_comb begin
        debug_rdata = '0;
        if (w_sel_stage) begin
            debug_rdata = w_stage_pad[{w_idx, 5'd0} +: 32];
        end else if (w_sel_rb) begin
            debug_rdata = w_rb_pad[{w_idx, 5'd0} +: 32];
        end else if (debug_addr == STATUS) begin
            debug_rdata = 32'(w_status);
        end else if (debug_addr == RDSEL) begin
            debug_rdata[FLD_ROW_LSB +: FLD_ROW_W]   = r_rd_row;
            debug_rdata[FLD_CHAN_LSB +: FLD_CHAN_W] = r_rd_chan;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prism_latch_sit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_prism_latch_sit_mc
// Purpose  : Directed scoreboard bench for prism_latch_sit_mc (default params).
// Revision : 1.0
// ============================================================================
module tb_prism_latch_sit_mc;

    localparam int WIDTH  = 80;
    localparam int DEPTH  = 4;
    localparam int NCH    = 2;
    localparam int A_BITS = 2;

    logic                   clk         = 1'b0;
    logic                   rst_n       = 1'b0;
    logic [5:0]             debug_addr  = '0;
    logic                   debug_wr    = 1'b0;
    logic [31:0]            debug_wdata = '0;
    logic [31:0]            debug_rdata;
    logic [NCH*A_BITS-1:0]  raddr       = '0;
    logic [NCH*WIDTH-1:0]   rdata;
    logic                   busy;
    logic [NCH-1:0]         rdata_perr;

    int          checks   = 0;
    int          failures = 0;
    logic [255:0] exp_q [$];
    string        tag_q [$];

    always #5 clk = ~clk;

    prism_latch_sit_mc #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NCH   (NCH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .debug_addr  (debug_addr),
        .debug_wr    (debug_wr),
        .debug_wdata (debug_wdata),
        .debug_rdata (debug_rdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .busy        (busy),
        .rdata_perr  (rdata_perr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [255:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [255:0] obs);
        logic [255:0] e;
        string        t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        debug_addr  = a;
        debug_wdata = d;
        debug_wr    = 1'b1;
        step();
        debug_wr    = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] e);
        debug_addr = a;
        expect_val(tag, 256'(e));
        #1;
        check(256'(debug_rdata));
    endtask

    task automatic expect_busy(input string tag, input logic e);
        expect_val(tag, 256'(e));
        check(256'(busy));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 10 && busy; i++) step();
        expect_busy(tag, 1'b0);
    endtask

    task automatic check_rdata(input string tag, input logic [NCH*WIDTH-1:0] e);
        #1;
        expect_val(tag, 256'(e));
        check(256'(rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] row_a;
        logic [79:0] row_b;
        logic [79:0] row_c;
        row_a = 80'hAB_22222222_11111111;
        row_b = 80'hCAFE_12345678_DEADBEEF;
        row_c = 80'h0C_0B0B0B0B_0A0A0A0A;

        // reset
        repeat (3) step();
        rst_n = 1'b1;
        step();
        expect_busy("reset_busy", 1'b0);
        for (int r = 0; r < DEPTH; r++) begin
            raddr = {2'(r), 2'(r)};
            check_rdata("reset_rdata", '0);
        end
        expect_val("reset_perr", 256'(0));
        check(256'(rdata_perr));
        rd_check("reset_status", 6'h14, 32'h0);
        for (int w = 0; w < 4; w++) rd_check("reset_rb", 6'(6'h20 + 4*w), 32'h0);
        rd_check("reset_stage0", 6'h00, 32'h0);

        // staging and truncation
        wr(6'h00, 32'h11111111);
        wr(6'h04, 32'h22222222);
        wr(6'h08, 32'hFFFFFFFF);
        rd_check("stage2_trunc", 6'h08, 32'h0000FFFF);
        wr(6'h0C, 32'hFFFFFFFF);
        rd_check("stage3_absent", 6'h0C, 32'h0);
        wr(6'h08, 32'h000000AB);

        // commit ch1 row3
        raddr = {2'd3, 2'd3};
        wr(6'h10, 32'h8000_0103);
        expect_busy("busy_t1", 1'b1);
        step();
        expect_busy("busy_t2", 1'b1);
        step();
        expect_busy("busy_t3", 1'b1);
        check_rdata("row_visible_t3", {row_a, 80'h0});
        step();
        expect_busy("busy_t4", 1'b0);
        rd_check("status_clean", 6'h14, 32'h0);
        rd_check("cmd_reads0", 6'h10, 32'h0);
        wr(6'h18, 32'h0000_0103);
        rd_check("rdsel", 6'h18, 32'h0000_0103);
        rd_check("rb0", 6'h20, 32'h11111111);
        rd_check("rb1", 6'h24, 32'h22222222);
        rd_check("rb2", 6'h28, 32'h000000AB);
        rd_check("rb3", 6'h2C, 32'h0);

        // commit ch0 row0
        wr(6'h00, 32'hDEADBEEF);
        wr(6'h04, 32'h12345678);
        wr(6'h08, 32'h0000CAFE);
        wr(6'h10, 32'h8000_0000);
        wait_idle("idle_ch0r0");
        raddr = {2'd3, 2'd0};
        check_rdata("two_rows", {row_a, row_b});
        wr(6'h18, 32'h0000_0004);
        rd_check("rb_row_oor", 6'h20, 32'h0);
        wr(6'h18, 32'h0000_0200);
        rd_check("rb_chan_oor", 6'h20, 32'h0);
        wr(6'h18, 32'h0000_0000);
        rd_check("rb_ch0r0", 6'h24, 32'h12345678);

        // go while busy and stage write while busy
        wr(6'h00, 32'h0A0A0A0A);
        wr(6'h04, 32'h0B0B0B0B);
        wr(6'h08, 32'h0000000C);
        wr(6'h10, 32'h8000_0001);
        wr(6'h10, 32'h8000_0002);
        wr(6'h00, 32'h55555555);
        wait_idle("idle_collide");
        raddr = {2'd3, 2'd1};
        check_rdata("first_row_ok", {row_a, row_c});
        raddr = {2'd3, 2'd2};
        check_rdata("second_go_ignored", {row_a, 80'h0});
        rd_check("stage_frozen", 6'h00, 32'h0A0A0A0A);
        rd_check("err_set", 6'h14, 32'h2);
        wr(6'h14, 32'h2);
        rd_check("err_clear", 6'h14, 32'h0);

        // out-of-range commands
        wr(6'h10, 32'h8000_0004);
        expect_busy("row_oor_busy", 1'b0);
        rd_check("row_oor_err", 6'h14, 32'h2);
        wr(6'h14, 32'h2);
        wr(6'h10, 32'h8000_0200);
        expect_busy("chan_oor_busy", 1'b0);
        rd_check("chan_oor_err", 6'h14, 32'h2);
        raddr = {2'd3, 2'd0};
        check_rdata("oor_no_change", {row_a, row_b});
        wr(6'h14, 32'h2);

        // reset during GATE
        wr(6'h10, 32'h8000_0102);
        step();
        rst_n = 1'b0;
        #1;
        expect_busy("rst_busy", 1'b0);
        check_rdata("rst_clear", '0);
        raddr = {2'd2, 2'd1};
        check_rdata("rst_clear_gated_row", '0);
        step();
        rst_n = 1'b1;
        step();
        rd_check("rst_status", 6'h14, 32'h0);
        expect_busy("rst_idle", 1'b0);

        // parity
        wr(6'h00, 32'h00000007);
        wr(6'h10, 32'h8000_0102);
        wait_idle("idle_par");
        raddr = {2'd2, 2'd0};
        check_rdata("par_row", {80'h7, 80'h0});
        expect_val("perr_clean", 256'(0));
        check(256'(rdata_perr));
`ifdef PRISM_SIT_PARITY_EN
        begin
            logic [WIDTH:0] flip;
            flip = dut.g_ch[1].u_bank.g_row[2].r_mem;
            force dut.g_ch[1].u_bank.g_row[2].r_mem = flip ^ 81'h1;
            #1;
            expect_val("perr_flip", 256'(2'b10));
            check(256'(rdata_perr));
            rd_check("status_perr", 6'h14, 32'h4);
            release dut.g_ch[1].u_bank.g_row[2].r_mem;
        end
`else
        rd_check("status_noperr", 6'h14, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
